fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode controller.
- Owns the PC and issues one outstanding instruction-memory request at a time.
- Buffers one returned instruction across stalls and presents {valid, pc, instr, opcode} to decode.
- Handles hazard-unit stalls and branch/jump redirects from EX.

Parameters:
PC_W, 32, PC and memory address width
INSTR_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous active-high reset
stall  input  1  hazard unit: hold IF/ID contents
redirect  input  1  EX: taken branch/JAL/JALR, flush and retarget
redirect_pc  input  PC_W  redirect target address
imem_req  output  1  fetch request valid
imem_ready  input  1  memory accepts request when imem_req && imem_ready
imem_addr  output  PC_W  fetch address (= pc)
imem_rvalid  input  1  response valid, exactly one per accepted request
imem_rdata  input  INSTR_W  returned instruction
if_id_valid  output  1  IF/ID holds a real instruction
if_id_pc  output  PC_W  PC of IF/ID instruction
if_id_instr  output  INSTR_W  IF/ID instruction; NOP (0x00000013) when invalid
if_id_opcode  output  7  if_id_instr[6:0], feeds decode Opcode

Behaviour:
- Reset (sync, any state, overrides all inputs): pc=RESET_PC, state=FETCH, buffer empty, if_id_valid=0, if_id_pc=0, if_id_instr=NOP, imem_req=0 during the reset cycle.
- FSM states:
  - FETCH: imem_req = !buf_valid && !redirect. On accept: req_pc<=pc, pc<=pc+4 (mod 2^PC_W), go WAIT.
  - WAIT: imem_req=0. On imem_rvalid, go FETCH.
  - DROP: imem_req=0. Discard the next imem_rvalid, then go FETCH.
- imem_addr and imem_req must be held stable while imem_req && !imem_ready (unless redirect).
- rvalid latency is arbitrary, >=1 cycle after accept. rvalid outside WAIT/DROP is ignored.
- IF/ID update priority, applied at each clock edge (highest first):
  1. redirect: if_id_valid<=0, instr<=NOP, buffer cleared, pc<=redirect_pc. WAIT without rvalid this cycle goes to DROP; WAIT with rvalid this cycle drops the data and goes to FETCH; DROP stays DROP. Redirect overrides stall.
  2. stall: IF/ID holds all fields. A response arriving in WAIT is written to the buffer (buf_valid<=1, buf_pc<=req_pc).
  3. buf_valid: IF/ID<=buffer, buffer cleared.
  4. rvalid in WAIT: IF/ID<={1, req_pc, imem_rdata}.
  5. Otherwise: bubble (if_id_valid<=0, instr<=NOP, pc field unchanged).
- Buffer depth is 1. A new request is blocked while buf_valid=1, so the buffer can never overflow.
- Best-case throughput: one instruction per 2 cycles with single-cycle memory (one outstanding request).
- Instruction reaches the IF/ID outputs the cycle after imem_rvalid.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined:
  - Adds output fetch_misalign (1 bit), a registered sticky flag.
  - Set when redirect=1 and redirect_pc[1:0]!=0. Cleared only by reset.
  - The misaligned redirect still flushes IF/ID but does not update pc and does not fetch.
  - FSM parks in FETCH with imem_req=0 until reset.
- Undefined:
  - Port absent.
  - redirect_pc is used verbatim; low bits are passed to imem_addr unchanged.

Test Plan:
- Reset with RESET_PC=0, memory ready=1, rvalid 1 cycle after accept, rdata=0x00500093 -> imem_addr sequence 0,4,8; IF/ID valid with pc=0, opcode=0x13 two cycles after first accept; bubbles between instructions.
- Stall asserted for 3 cycles while a request to 0x8 is in flight -> IF/ID holds its prior instr; returned word is buffered; no new imem_req while buffered; after stall drops, IF/ID pc=0x8 next cycle, then request to 0xC issues.
- Redirect to 0x100 while in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> IF/ID invalid/NOP; stale data never appears; next imem_addr=0x100.
- Redirect to 0x40 in the same cycle as rvalid and stall=1 -> data dropped, buffer empty, IF/ID NOP, next request addr=0x40.
- pc=0xFFFFFFFC fetched -> next imem_addr=0x00000000; reset asserted mid-WAIT -> state FETCH, pc=RESET_PC, late rvalid ignored.
- FETCH_MISALIGN_CHECK_EN: redirect_pc=0x102 -> fetch_misalign=1 next cycle, imem_req stays 0, IF/ID NOP until reset.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, keeps a single instruction-memory request in flight, holds one
// returned word across hazard stalls, and flushes/retargets on EX redirects.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds sticky fetch_misalign).
module fetch_stage #(
    parameter int unsigned           PC_W     = 32,
    parameter int unsigned           INSTR_W  = 32,
    parameter logic [PC_W-1:0]       RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    input  logic               imem_ready,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_valid,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [6:0]         if_id_opcode
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic               fetch_misalign
`endif
);

    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DROP
    } state_t;

    state_t             state, state_n;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    req_pc;
    logic               buf_valid;
    logic [PC_W-1:0]    buf_pc;
    logic [INSTR_W-1:0] buf_instr;
    logic               accept;
    logic               rsp;
    logic               bad_redirect;
    logic               parked;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    assign bad_redirect   = redirect && (redirect_pc[1:0] != 2'b00);
    assign parked         = misalign_q;
    assign fetch_misalign = misalign_q;

    // Sticky misaligned-redirect flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset)
            misalign_q <= 1'b0;
        else if (bad_redirect)
            misalign_q <= 1'b1;
    end
`else
    assign bad_redirect = 1'b0;
    assign parked       = 1'b0;
`endif

    assign imem_addr    = pc;
    assign accept       = imem_req && imem_ready;
    assign rsp          = (state == S_WAIT) && imem_rvalid;
    assign if_id_opcode = if_id_instr[6:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= state_n;
    end

    // Request generation and next-state selection
    always_comb begin
        imem_req = 1'b0;
        state_n  = state;
        case (state)
            S_FETCH: begin
                imem_req = !buf_valid && !redirect && !reset && !parked;
                if (imem_req && imem_ready)
                    state_n = S_WAIT;
            end
            S_WAIT: begin
                // A redirect before the response arrives leaves that response
                // still owed by memory, so it must be swallowed in DROP.
                if (redirect)
                    state_n = imem_rvalid ? S_FETCH : S_DROP;
                else if (imem_rvalid)
                    state_n = S_FETCH;
            end
            S_DROP: begin
                if (imem_rvalid)
                    state_n = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
        if (bad_redirect)
            state_n = S_FETCH;
    end

    // PC, request PC, skid buffer and IF/ID register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            req_pc      <= '0;
            buf_valid   <= 1'b0;
            buf_pc      <= '0;
            buf_instr   <= NOP;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP;
        end else begin
            if (redirect) begin
                if (!bad_redirect)
                    pc <= redirect_pc;
            end else if (accept) begin
                pc <= pc + PC_W'(4);
            end

            if (accept)
                req_pc <= pc;

            if (redirect) begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP;
                buf_valid   <= 1'b0;
            end else if (stall) begin
                if (rsp) begin
                    buf_valid <= 1'b1;
                    buf_pc    <= req_pc;
                    buf_instr <= imem_rdata;
                end
            end else if (buf_valid) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= buf_pc;
                if_id_instr <= buf_instr;
                buf_valid   <= 1'b0;
            end else if (rsp) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= req_pc;
                if_id_instr <= imem_rdata;
            end else begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a latency-programmable memory model
// feeds a scoreboard of expected IF/ID contents; directed phases cover the
// basic fetch loop, stall buffering, redirects, PC wrap and reset mid-request.
module tb_fetch_stage;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] RST_PC  = 32'h0;
    localparam logic [31:0] NOP     = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_instr;
    logic [6:0]  if_id_opcode;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    fetch_stage #(
        .PC_W(PC_W),
        .INSTR_W(INSTR_W),
        .RESET_PC(RST_PC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_ready(imem_ready),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid),
        .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr),
        .if_id_opcode(if_id_opcode)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misalign(fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sbq[$];

    // memory model and reference state
    bit          pend = 0;
    logic [31:0] pend_addr = '0;
    int          cnt = 0;
    int          lat = 1;
    bit          drop_rsp = 0;
    bit          force_en = 0;
    logic [31:0] force_data = '0;
    logic [31:0] exp_pc = RST_PC;
    bit          hold_prev = 0;
    logic [31:0] hold_addr = '0;
    bit          cur_req, cur_acc;
    logic [31:0] cur_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a << 7) ^ 32'h0050_0093;
    endfunction

    // One clock cycle: drive memory response, sample request, clock, check IF/ID.
    task automatic tick();
        bit          fire;
        bit          s_v;
        logic [31:0] s_pc, s_instr;
        exp_t        e;
        fire = 0;
        if (pend) begin
            if (cnt == 0) fire = 1;
            else cnt--;
        end
        imem_rvalid = fire;
        imem_rdata  = fire ? (force_en ? force_data : instr_of(pend_addr)) : $urandom;
        if (fire) begin
            pend = 0;
            if (!reset && !redirect && !drop_rsp)
                sbq.push_back('{pend_addr, imem_rdata});
            drop_rsp = 0;
        end else if (pend && redirect) begin
            drop_rsp = 1;
        end
        if (reset && pend) drop_rsp = 1;
        #1;
        if (hold_prev && !redirect && !reset) begin
            check("req_hold", imem_req, 1);
            check("addr_hold", imem_addr, hold_addr);
        end
        cur_req  = imem_req;
        cur_addr = imem_addr;
        cur_acc  = imem_req && imem_ready;
        if (cur_acc) begin
            check("fetch_addr", imem_addr, exp_pc);
            pend      = 1;
            pend_addr = imem_addr;
            cnt       = lat - 1;
        end
        hold_prev = imem_req && !imem_ready;
        hold_addr = imem_addr;
        s_v = if_id_valid; s_pc = if_id_pc; s_instr = if_id_instr;
        if (reset) exp_pc = RST_PC;
        else if (redirect) begin
            if (!(MIS && redirect_pc[1:0] != 2'b00)) exp_pc = redirect_pc;
        end else if (cur_acc) exp_pc = exp_pc + 32'd4;
        if (reset || redirect) sbq.delete();
        @(posedge clk);
        @(negedge clk);
        if (reset) begin
            check("rst_valid", if_id_valid, 0);
            check("rst_pc", if_id_pc, 0);
            check("rst_instr", if_id_instr, NOP);
        end else if (redirect) begin
            check("flush_valid", if_id_valid, 0);
            check("flush_instr", if_id_instr, NOP);
        end else if (stall) begin
            check("stall_valid", if_id_valid, s_v);
            check("stall_pc", if_id_pc, s_pc);
            check("stall_instr", if_id_instr, s_instr);
        end else if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("sb_valid", if_id_valid, 1);
            check("sb_pc", if_id_pc, e.pc);
            check("sb_instr", if_id_instr, e.instr);
            check("sb_opcode", if_id_opcode, e.instr[6:0]);
        end else begin
            check("bubble_valid", if_id_valid, 0);
            check("bubble_instr", if_id_instr, NOP);
        end
    endtask

    task automatic wait_accept(input string tag, input logic [31:0] a);
        bit got;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            got = cur_acc;
        end
        check({tag, "_seen"}, got, 1);
        if (got) check(tag, cur_addr, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1; stall = 0; redirect = 0; redirect_pc = '0;
        imem_ready = 1; imem_rvalid = 0; imem_rdata = '0;
        @(negedge clk);
        tick();
        check("rst_req", cur_req, 0);
        tick();
        reset = 0;

        // basic fetch loop
        tick();
        check("t1_req", cur_req, 1);
        check("t1_addr", cur_addr, 32'h0);
        tick();
        check("t2_valid", if_id_valid, 1);
        check("t2_pc", if_id_pc, 32'h0);
        check("t2_opcode", if_id_opcode, 7'h13);
        tick();
        check("t3_addr", cur_addr, 32'h4);
        check("t3_bubble", if_id_valid, 0);
        tick();

        // stall for 3 cycles with request to 0x8 in flight
        lat = 2; stall = 1;
        tick();
        check("t5_addr", cur_addr, 32'h8);
        check("t5_hold_pc", if_id_pc, 32'h4);
        tick();
        tick();
        check("t7_hold_pc", if_id_pc, 32'h4);
        check("t7_hold_valid", if_id_valid, 1);
        stall = 0; lat = 3;
        tick();
        check("t8_req_blocked", cur_req, 0);
        check("t8_pc", if_id_pc, 32'h8);
        check("t8_valid", if_id_valid, 1);
        tick();
        check("t9_req", cur_req, 1);
        check("t9_addr", cur_addr, 32'hC);

        // redirect while waiting; stale word must be discarded
        redirect = 1; redirect_pc = 32'h100; force_en = 1; force_data = 32'hDEAD_BEEF;
        tick();
        check("t10_req", cur_req, 0);
        redirect = 0;
        tick();
        tick();
        check("t12_stale_instr", if_id_instr, NOP);
        check("t12_stale_valid", if_id_valid, 0);
        force_en = 0; lat = 1;
        tick();
        check("t13_req", cur_req, 1);
        check("t13_addr", cur_addr, 32'h100);

        // redirect coinciding with response and stall
        stall = 1; redirect = 1; redirect_pc = 32'h40;
        tick();
        check("t14_valid", if_id_valid, 0);
        check("t14_instr", if_id_instr, NOP);
        stall = 0; redirect = 0;
        tick();
        check("t15_req", cur_req, 1);
        check("t15_addr", cur_addr, 32'h40);
        tick();
        check("t16_pc", if_id_pc, 32'h40);

        // mixed traffic
        for (int i = 0; i < 80; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            imem_ready  = ($urandom_range(0, 2) != 0);
            lat         = $urandom_range(1, 3);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = 32'($urandom_range(0, 255)) << 2;
            tick();
        end
        stall = 0; redirect = 0; imem_ready = 1; lat = 1;

        // PC wrap
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 0;
        wait_accept("wrap_top", 32'hFFFF_FFFC);
        lat = 3;
        wait_accept("wrap_zero", 32'h0);

        // reset while waiting; late response ignored
        reset = 1;
        tick();
        reset = 0; imem_ready = 0;
        tick();
        check("post_rst_req", cur_req, 1);
        check("post_rst_addr", cur_addr, RST_PC);
        tick();
        check("late_rv_valid", if_id_valid, 0);
        imem_ready = 1; lat = 1;
        tick();
        check("refetch_acc", cur_acc, 1);
        check("refetch_addr", cur_addr, RST_PC);
        tick();
        check("refetch_valid", if_id_valid, 1);
        check("refetch_pc", if_id_pc, RST_PC);

`ifdef FETCH_MISALIGN_CHECK_EN
        redirect = 1; redirect_pc = 32'h102;
        tick();
        redirect = 0;
        check("mis_flag", fetch_misalign, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mis_req", cur_req, 0);
            check("mis_valid", if_id_valid, 0);
            check("mis_sticky", fetch_misalign, 1);
        end
        reset = 1;
        tick();
        reset = 0;
        check("mis_clear", fetch_misalign, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
